// File: rtl/axi_single_beat_mem.sv
// Flop-based AXI4 subordinate memory for single-beat traffic.
// Multi-beat or atomic requests get SLVERR; addresses past the memory get DECERR.
// Read and write channels run as independent FSMs.

package axi_single_beat_mem_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [2:0]           prot;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
        logic [UserWidth-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic [2:0]           prot;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

module axi_single_beat_mem #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned NumWords  = 256,
    parameter type axi_req_t  = axi_single_beat_mem_pkg::axi_req_t,
    parameter type axi_resp_t = axi_single_beat_mem_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = $clog2(NumWords);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData}        r_state_e;

    // Bursts and atomics are refused first; otherwise anything above the array decodes to nothing.
    function automatic logic [1:0] err_code(input logic [AddrWidth-1:0] addr,
                                            input logic [7:0]           len,
                                            input logic [5:0]           atop);
        if ((len != 8'd0) || (atop != 6'd0)) begin
            return RespSlvErr;
        end else if (addr[AddrWidth-1:OffW+IdxW] != '0) begin
            return RespDecErr;
        end
        return RespOkay;
    endfunction

    logic [DataWidth-1:0] mem_q [NumWords];

    w_state_e             w_state_q, w_state_d;
    logic [IdWidth-1:0]   w_id_q, w_id_d;
    logic [IdxW-1:0]      w_idx_q, w_idx_d;
    logic [7:0]           w_cnt_q, w_cnt_d;
    logic [1:0]           w_err_q, w_err_d;
    logic                 w_we;
    logic [DataWidth-1:0] w_merged;

    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [7:0]           r_cnt_q, r_cnt_d;
    logic [1:0]           r_err_q, r_err_d;
    logic [DataWidth-1:0] r_data_q, r_data_d;

    logic            aw_ready, w_ready, ar_ready;
    logic [1:0]      ar_err;
    logic [IdxW-1:0] ar_idx;

    assign aw_ready = (w_state_q == WIdle) && !rst_i;
    assign w_ready  = (w_state_q == WData) && !rst_i;
    assign ar_ready = (r_state_q == RIdle) && !rst_i;
    assign ar_err   = err_code(slv_req_i.ar.addr, slv_req_i.ar.len, 6'd0);
    assign ar_idx   = slv_req_i.ar.addr[OffW+IdxW-1:OffW];

    // Merge the incoming beat with the old word lane by lane under the strobes.
    for (genvar gi = 0; gi < StrbW; gi++) begin : g_lane
        assign w_merged[8*gi +: 8] = slv_req_i.w.strb[gi] ? slv_req_i.w.data[8*gi +: 8]
                                                          : mem_q[w_idx_q][8*gi +: 8];
    end

    // Write FSM next state: accept AW, consume len+1 beats, then hold B until taken.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_we      = 1'b0;
        case (w_state_q)
            WIdle: begin
                if (slv_req_i.aw_valid && aw_ready) begin
                    w_id_d    = slv_req_i.aw.id;
                    w_idx_d   = slv_req_i.aw.addr[OffW+IdxW-1:OffW];
                    w_cnt_d   = slv_req_i.aw.len;
                    w_err_d   = err_code(slv_req_i.aw.addr, slv_req_i.aw.len, slv_req_i.aw.atop);
                    w_state_d = WData;
                end
            end
            WData: begin
                if (slv_req_i.w_valid && w_ready) begin
                    // Errored bursts are drained without touching memory.
                    w_we = (w_err_q == RespOkay);
                    if (w_cnt_q == 8'd0) begin
                        w_state_d = WResp;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                    end
                end
            end
            WResp: begin
                if (slv_req_i.b_ready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Write FSM state and latched AW fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // Memory array: cleared on reset, one merged word written per accepted beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_we) begin
            mem_q[w_idx_q] <= w_merged;
        end
    end

    // Read FSM next state: sample the word at AR acceptance and replay it for every beat.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        r_err_d   = r_err_q;
        r_data_d  = r_data_q;
        case (r_state_q)
            RIdle: begin
                if (slv_req_i.ar_valid && ar_ready) begin
                    r_id_d    = slv_req_i.ar.id;
                    r_cnt_d   = slv_req_i.ar.len;
                    r_err_d   = ar_err;
                    r_data_d  = (ar_err == RespOkay) ? mem_q[ar_idx] : '0;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (slv_req_i.r_ready) begin
                    if (r_cnt_q == 8'd0) begin
                        r_state_d = RIdle;
                    end else begin
                        r_cnt_d = r_cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Read FSM state and latched AR fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= '0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            r_data_q  <= r_data_d;
        end
    end

    // Response struct: readies gated by reset, everything else straight from registers.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.b_valid  = (w_state_q == WResp);
        slv_resp_o.b.id     = w_id_q;
        slv_resp_o.b.resp   = w_err_q;
        slv_resp_o.r_valid  = (r_state_q == RData);
        slv_resp_o.r.id     = r_id_q;
        slv_resp_o.r.data   = r_data_q;
        slv_resp_o.r.resp   = r_err_q;
        slv_resp_o.r.last   = (r_state_q == RData) && (r_cnt_q == 8'd0);
    end

    // Request fields this memory has no use for.
    logic unused_inputs;
    assign unused_inputs = ^{slv_req_i.aw.size, slv_req_i.aw.burst, slv_req_i.aw.prot,
                             slv_req_i.aw.user, slv_req_i.w.last, slv_req_i.w.user,
                             slv_req_i.ar.size, slv_req_i.ar.burst, slv_req_i.ar.prot,
                             slv_req_i.ar.user};

    if (OffW > 0) begin : g_off
        logic unused_offset;
        assign unused_offset = ^{slv_req_i.aw.addr[OffW-1:0], slv_req_i.ar.addr[OffW-1:0]};
    end

endmodule
